sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port round-robin arbiter that shares the SDRAM controller's Avalon-MM slave port (25-bit word address, 16-bit data) between two requesters, for example the test sequencer and a DMA/display engine. It registers each command, holds it stable through `waitrequest`, and pulses a grant to the owning port. It tracks outstanding reads in order, so each `readdatavalid` beat is routed back to the port that issued the read. The block sits between the requester logic and the `sdram` controller instance, in place of a single direct `sdram_interface` connection.

## Interface
- `MAX_PENDING`, 4: maximum outstanding reads; power of two, 2..16.
- `clk_clk`  in  1  system clock; all logic is on the rising edge.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  command request; held with its payload until the matching `mN_gnt` is seen.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  25  word address.
- `m0_wdata`, `m1_wdata`  in  16  write data.
- `m0_be_n`, `m1_be_n`  in  2  byte enables, active low.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: the command has been accepted by the SDRAM controller.
- `m0_rdata`, `m1_rdata`  out  16  read data; valid while `mN_rvalid` is high.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle read-return pulse.
- `err`  out  1  sticky flag: `readdatavalid` arrived with no read pending.
- `sdram_address` out 25, `sdram_byteenable_n` out 2, `sdram_chipselect` out 1, `sdram_writedata` out 16, `sdram_read_n` out 1, `sdram_write_n` out 1: Avalon-MM master outputs, all registered.
- `sdram_readdata` in 16, `sdram_readdatavalid` in 1, `sdram_waitrequest` in 1: Avalon-MM master inputs.

## Operation
- **Reset values:**
  - `sdram_chipselect` = 0, `sdram_read_n` = 1, `sdram_write_n` = 1.
  - `sdram_address` = 0, `sdram_writedata` = 0, `sdram_byteenable_n` = 2'b11.
  - All `mN_gnt` and `mN_rvalid` = 0; `mN_rdata` = 0; `err` = 0.
  - Pending FIFO empty; round-robin pointer = 1, so port 0 wins the first tie.
- **State machine:**
  - **IDLE:**
    - A port is eligible when `req` = 1, and for a read (`we` = 0) the pending FIFO is not full.
    - If no port is eligible, stay in IDLE.
    - If exactly one port is eligible, select it.
    - If both are eligible, select the port that is not the round-robin pointer.
    - On selection, latch address, data and byte enables into the Avalon output registers; drive `chipselect` = 1 and either `read_n` = 0 or `write_n` = 0. Go to ISSUE.
  - **ISSUE:**
    - Hold every Avalon output constant while `sdram_waitrequest` = 1.
    - On an edge where `waitrequest` = 0, the command is accepted:
      - deassert `chipselect`, `read_n` and `write_n`;
      - set the round-robin pointer to the owning port;
      - if the command is a read, push the owning port ID into the pending FIFO;
      - go to ACK.
  - **ACK:** drive `mN_gnt` = 1 for the owning port only; go to IDLE. Requests are not sampled in this state.
- **Read return:**
  - On `sdram_readdatavalid` = 1 with the FIFO not empty: pop the head ID, copy `sdram_readdata` to that port's `rdata`, and pulse its `rvalid`.
  - On `readdatavalid` with the FIFO empty: discard the data and set `err`.
- **Boundary conditions:**
  - Push and pop on the same edge: occupancy is unchanged; both operations take effect.
  - FIFO full: reads are ineligible and writes still issue. A port whose read is blocked does not block the other port.
  - FIFO read/write pointers wrap modulo `MAX_PENDING`; occupancy is a counter of `$clog2(MAX_PENDING)+1` bits.
  - Reset mid-operation: the command is abandoned and the FIFO is cleared. Any late `readdatavalid` then sets `err` (expected after a warm reset).
  - `mN_rdata` holds its last value between `rvalid` pulses.

## Timing
- Request seen in IDLE at cycle N → Avalon command on the bus in cycle N+1.
- Accepted at the end of cycle N+1+W, where W = number of `waitrequest` cycles → `mN_gnt` high in cycle N+2+W.
- Back-to-back throughput: at most one command per 3 cycles.
- `sdram_readdatavalid` in cycle R → `mN_rvalid` and `mN_rdata` in cycle R+1.
- There is no combinational path from any input to any output.

## Configuration
- `SDRAM_ARB_STATS_EN` defined:
  - adds outputs `m0_cmd_cnt` and `m1_cmd_cnt`, each 32 bits;
  - each counter increments on every accepted command for its port;
  - counters reset to 0 and wrap at 2^32.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `sdram_arb_pkg` holds:
  - `SDRAM_AW` = 25, `SDRAM_DW` = 16, `SDRAM_BEW` = 2;
  - `arb_state_t` enum with values IDLE, ISSUE, ACK;
  - `port_id_t`, a 1-bit type.
- Sub-module `sdram_arb_tag_fifo` implements the pending-read FIFO:
  - inputs: push, pop, din;
  - outputs: dout, full, empty;
  - parameterised by `MAX_PENDING`.

## Test plan
- **Single write:** m0 writes 16'h0042 to 25'h100000, `waitrequest` = 0 → Avalon `write_n` low for 1 cycle with that address and data; `m0_gnt` pulses 1 cycle later; FIFO stays empty.
- **Contention:** m0 and m1 request reads continuously → grants alternate 0,1,0,1 starting with port 0.
- **Waitrequest hold:** `waitrequest` = 1 for 5 cycles → Avalon outputs are bit-identical across all 5 cycles; `gnt` follows the release by 1 cycle.
- **Read routing:** reads m0@0x10, m1@0x20, m0@0x30, each returned 4 cycles after acceptance with data 0xAAAA, 0xBBBB, 0xCCCC → ports receive 0xAAAA, 0xBBBB, 0xCCCC in order, each on the correct port's `rvalid`.
- **FIFO full:** with `MAX_PENDING` = 4 and no returns, m0 reads 4 times → the 5th read stalls while an m1 write is still granted. One return then allows the 5th read to issue.
- **Error and reset:** `readdatavalid` with an empty FIFO → `err` = 1 and stays sticky. `reset_reset` pulsed mid-ISSUE → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

    localparam int SDRAM_AW  = 25;
    localparam int SDRAM_DW  = 16;
    localparam int SDRAM_BEW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Identifies which requester owns a command or a pending read.
    typedef logic port_id_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Pending-read tag FIFO: remembers which port issued each outstanding read, in order.
// Latency: pushed tag is visible on dout the cycle after push when the FIFO was empty.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
//
// Ports: clk/rst (async active-high), push/din (tag in), pop (consume head),
//        dout (head tag), full, empty.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  port_id_t din,
    output port_id_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(MAX_PENDING);

    port_id_t        r_mem [MAX_PENDING];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_count == DEPTH);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly PW bits wide, so they wrap modulo MAX_PENDING for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of an Avalon-MM SDRAM controller slave.
// Latency: request seen in IDLE -> command on bus next cycle; gnt one cycle after acceptance;
//          readdatavalid -> port rvalid/rdata one cycle later.
// Backpressure: waitrequest holds the registered command; reads stall while the tag FIFO is full.
//
// Ports: clk_clk, reset_reset (async active-high); m0_*/m1_* requester command, grant and
//        read-return ports; err (sticky unexpected readdatavalid); sdram_* Avalon-MM master.
// Optional: SDRAM_ARB_STATS_EN adds m0_cmd_cnt/m1_cmd_cnt accepted-command counters.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [SDRAM_AW-1:0]  m0_addr,
    input  logic [SDRAM_DW-1:0]  m0_wdata,
    input  logic [SDRAM_BEW-1:0] m0_be_n,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [SDRAM_AW-1:0]  m1_addr,
    input  logic [SDRAM_DW-1:0]  m1_wdata,
    input  logic [SDRAM_BEW-1:0] m1_be_n,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic [SDRAM_DW-1:0]  m0_rdata,
    output logic [SDRAM_DW-1:0]  m1_rdata,
    output logic                 m0_rvalid,
    output logic                 m1_rvalid,
    output logic                 err,
    output logic [SDRAM_AW-1:0]  sdram_address,
    output logic [SDRAM_BEW-1:0] sdram_byteenable_n,
    output logic                 sdram_chipselect,
    output logic [SDRAM_DW-1:0]  sdram_writedata,
    output logic                 sdram_read_n,
    output logic                 sdram_write_n,
    input  logic [SDRAM_DW-1:0]  sdram_readdata,
    input  logic                 sdram_readdatavalid,
    input  logic                 sdram_waitrequest
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]          m0_cmd_cnt,
    output logic [31:0]          m1_cmd_cnt
`endif
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    port_id_t             r_owner;
    port_id_t             r_rr_ptr;
    logic [SDRAM_AW-1:0]  r_address;
    logic [SDRAM_BEW-1:0] r_be_n;
    logic [SDRAM_DW-1:0]  r_wdata;
    logic                 r_cs;
    logic                 r_read_n;
    logic                 r_write_n;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_rvalid0;
    logic                 r_rvalid1;
    logic [SDRAM_DW-1:0]  r_rdata0;
    logic [SDRAM_DW-1:0]  r_rdata1;
    logic                 r_err;

    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_sel_vld;
    port_id_t             w_sel_port;
    logic                 w_accept;
    logic                 w_sel_we;
    logic [SDRAM_AW-1:0]  w_sel_addr;
    logic [SDRAM_DW-1:0]  w_sel_wdata;
    logic [SDRAM_BEW-1:0] w_sel_be_n;
    logic                 w_push;
    logic                 w_pop;
    port_id_t             w_fifo_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // A blocked read on one port must not starve a write on the other,
    // so eligibility is evaluated per port.
    assign w_elig0 = m0_req & (m0_we | ~w_fifo_full);
    assign w_elig1 = m1_req & (m1_we | ~w_fifo_full);

    assign w_sel_we    = w_sel_port ? m1_we    : m0_we;
    assign w_sel_addr  = w_sel_port ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_sel_port ? m1_wdata : m0_wdata;
    assign w_sel_be_n  = w_sel_port ? m1_be_n  : m0_be_n;

    // read_n is low only while a read is on the bus, so it marks a read at acceptance.
    assign w_push = w_accept & ~r_read_n;
    assign w_pop  = sdram_readdatavalid & ~w_fifo_empty;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_vld   = 1'b0;
        w_sel_port  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_sel_vld   = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    w_sel_port  = (w_elig0 && w_elig1) ? ~r_rr_ptr : w_elig1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!sdram_waitrequest) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command path: bus registers load on selection and are frozen until acceptance.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_owner   <= 1'b0;
            r_rr_ptr  <= 1'b1;
            r_address <= '0;
            r_be_n    <= '1;
            r_wdata   <= '0;
            r_cs      <= 1'b0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
        end else begin
            r_gnt0 <= w_accept & (r_owner == 1'b0);
            r_gnt1 <= w_accept & (r_owner == 1'b1);
            if (w_sel_vld) begin
                r_owner   <= w_sel_port;
                r_address <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
                r_be_n    <= w_sel_be_n;
                r_cs      <= 1'b1;
                r_read_n  <= w_sel_we;
                r_write_n <= ~w_sel_we;
            end else if (w_accept) begin
                r_cs      <= 1'b0;
                r_read_n  <= 1'b1;
                r_write_n <= 1'b1;
                r_rr_ptr  <= r_owner;
            end
        end
    end

    // Return path: route each beat to the port at the head of the tag FIFO.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (sdram_readdatavalid) begin
                if (w_fifo_empty) begin
                    r_err <= 1'b1;
                end else if (w_fifo_head == 1'b0) begin
                    r_rdata0  <= sdram_readdata;
                    r_rvalid0 <= 1'b1;
                end else begin
                    r_rdata1  <= sdram_readdata;
                    r_rvalid1 <= 1'b1;
                end
            end
        end
    end

    sdram_arb_tag_fifo #(
        .MAX_PENDING (MAX_PENDING)
    ) u_tag_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_owner),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign sdram_address      = r_address;
    assign sdram_byteenable_n = r_be_n;
    assign sdram_chipselect   = r_cs;
    assign sdram_writedata    = r_wdata;
    assign sdram_read_n       = r_read_n;
    assign sdram_write_n      = r_write_n;
    assign m0_gnt             = r_gnt0;
    assign m1_gnt             = r_gnt1;
    assign m0_rvalid          = r_rvalid0;
    assign m1_rvalid          = r_rvalid1;
    assign m0_rdata           = r_rdata0;
    assign m1_rdata           = r_rdata1;
    assign err                = r_err;

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] r_cmd_cnt0;
    logic [31:0] r_cmd_cnt1;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cmd_cnt0 <= '0;
            r_cmd_cnt1 <= '0;
        end else if (w_accept) begin
            if (r_owner == 1'b1) begin
                r_cmd_cnt1 <= r_cmd_cnt1 + 32'd1;
            end else begin
                r_cmd_cnt0 <= r_cmd_cnt0 + 32'd1;
            end
        end
    end

    assign m0_cmd_cnt = r_cmd_cnt0;
    assign m1_cmd_cnt = r_cmd_cnt1;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    typedef struct { logic we; logic [24:0] addr; logic [15:0] wdata; logic [1:0] be_n; } cmd_t;
    typedef struct { int port; int cyc; } gexp_t;
    typedef struct { logic [15:0] data; int cyc; } rexp_t;
    typedef struct { int port; int due; } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [24:0] t_addr  [2];
    logic [15:0] t_wdata [2];
    logic [1:0]  t_be    [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata   [2];
    logic        err;
    logic [24:0] s_addr;
    logic [1:0]  s_be;
    logic        s_cs;
    logic [15:0] s_wdata;
    logic        s_rd_n;
    logic        s_wr_n;
    logic [15:0] s_rdata;
    logic        s_rdv;
    logic        s_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Stimulus / model controls (written only by the main sequence)
    int ws_fixed  = 0;   // wait states per command; negative = random
    int ret_dly   = 4;   // read return delay after acceptance; negative = random
    bit ret_hold  = 0;
    int inj_req   = 0;

    cmd_t        q0[$];
    cmd_t        q1[$];
    gexp_t       gq[$];
    rexp_t       rq0[$];
    rexp_t       rq1[$];
    pend_t       rd_pend[$];
    logic [15:0] ret_data[$];
    int          gnt_log[$];
    int          rd_log_port[$];
    logic [15:0] rd_log_data[$];
    int          last_on_bus = 0;

    sdram_arbiter #(.MAX_PENDING(4)) dut (
        .clk_clk             (clk),
        .reset_reset         (rst),
        .m0_req              (t_req[0]),
        .m0_we               (t_we[0]),
        .m0_addr             (t_addr[0]),
        .m0_wdata            (t_wdata[0]),
        .m0_be_n             (t_be[0]),
        .m1_req              (t_req[1]),
        .m1_we               (t_we[1]),
        .m1_addr             (t_addr[1]),
        .m1_wdata            (t_wdata[1]),
        .m1_be_n             (t_be[1]),
        .m0_gnt              (gnt[0]),
        .m1_gnt              (gnt[1]),
        .m0_rdata            (rdata[0]),
        .m1_rdata            (rdata[1]),
        .m0_rvalid           (rvalid[0]),
        .m1_rvalid           (rvalid[1]),
        .err                 (err),
        .sdram_address       (s_addr),
        .sdram_byteenable_n  (s_be),
        .sdram_chipselect    (s_cs),
        .sdram_writedata     (s_wdata),
        .sdram_read_n        (s_rd_n),
        .sdram_write_n       (s_wr_n),
        .sdram_readdata      (s_rdata),
        .sdram_readdatavalid (s_rdv),
        .sdram_waitrequest   (s_wr)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [45:0] bus_now();
        return {s_cs, s_rd_n, s_wr_n, s_addr, s_wdata, s_be};
    endfunction

    // Which requester is currently presenting exactly the command on the bus.
    function automatic int match_port();
        for (int p = 0; p < 2; p++) begin
            if (t_req[p] && (t_we[p] == !s_wr_n) && (t_addr[p] == s_addr) &&
                (t_wdata[p] == s_wdata) && (t_be[p] == s_be))
                return p;
        end
        return -1;
    endfunction

    // ---------------- requester driver ----------------
    initial begin
        cmd_t c;
        bit   got;
        for (int p = 0; p < 2; p++) begin
            t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0; t_be[p] = 2'b11;
        end
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (t_req[p] && gnt[p]) t_req[p] = 1'b0;
                if (!t_req[p]) begin
                    got = 0;
                    if (p == 0 && q0.size() > 0) begin c = q0.pop_front(); got = 1; end
                    if (p == 1 && q1.size() > 0) begin c = q1.pop_front(); got = 1; end
                    if (got) begin
                        t_req[p] = 1'b1; t_we[p] = c.we; t_addr[p] = c.addr;
                        t_wdata[p] = c.wdata; t_be[p] = c.be_n;
                    end
                end
            end
        end
    end

    // ---------------- SDRAM slave model ----------------
    initial begin
        bit          prev_pend = 0;
        logic [45:0] snap = '0;
        int          hold_cnt = 0, on_bus = 0, last_due = 0, inj_done = 0;
        int          mp, dly, due;
        pend_t       pe;
        logic [15:0] d;
        s_wr = 1'b0; s_rdv = 1'b0; s_rdata = '0;
        forever begin
            @(negedge clk);
            s_rdv = 1'b0;
            if (rst) begin
                prev_pend = 0;
                s_wr = 1'b0;
            end else begin
                if (prev_pend) chk("hold_stable", 64'(bus_now()), 64'(snap));
                if (s_cs) begin
                    if (!prev_pend) begin hold_cnt = 0; on_bus = 0; end
                    on_bus++;
                    if (ws_fixed >= 0) s_wr = (hold_cnt < ws_fixed);
                    else s_wr = ($urandom_range(0, 2) == 0);
                    hold_cnt++;
                    if (s_wr) begin
                        prev_pend = 1;
                        snap = bus_now();
                    end else begin
                        prev_pend = 0;
                        mp = match_port();
                        chk("cmd_match", 64'(mp >= 0), 64'd1);
                        if (mp < 0) mp = 0;
                        chk("cmd_kind", 64'({s_rd_n, s_wr_n}), t_we[mp] ? 64'd2 : 64'd1);
                        gq.push_back('{mp, cyc + 1});
                        last_on_bus = on_bus;
                        if (!t_we[mp]) begin
                            dly = (ret_dly < 0) ? int'($urandom_range(1, 6)) : ret_dly;
                            due = cyc + dly;
                            if (due <= last_due) due = last_due + 1;
                            last_due = due;
                            rd_pend.push_back('{mp, due});
                        end
                    end
                end else begin
                    prev_pend = 0;
                    s_wr = 1'b0;
                end
                if (inj_req != inj_done) begin
                    inj_done++;
                    s_rdv = 1'b1;
                    s_rdata = 16'hDEAD;
                end else if (!ret_hold && rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
                    pe = rd_pend.pop_front();
                    d = (ret_data.size() > 0) ? ret_data.pop_front() : 16'($urandom);
                    s_rdv = 1'b1;
                    s_rdata = d;
                    if (pe.port == 0) rq0.push_back('{d, cyc + 1});
                    else rq1.push_back('{d, cyc + 1});
                end
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin
        logic [15:0] last_rd [2];
        gexp_t       ge;
        rexp_t       re;
        bit          due_now;
        last_rd[0] = '0; last_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd[0] = '0; last_rd[1] = '0;
            end else begin
                if (gnt != 2'b00) gnt_log.push_back(gnt[1] ? 1 : 0);
                if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                    ge = gq.pop_front();
                    chk("gnt", 64'(gnt), (ge.port == 1) ? 64'd2 : 64'd1);
                end else if (gnt != 2'b00) begin
                    chk("gnt_unexpected", 64'(gnt), 64'd0);
                end
                for (int p = 0; p < 2; p++) begin
                    if (rvalid[p]) begin
                        rd_log_port.push_back(p);
                        rd_log_data.push_back(rdata[p]);
                    end
                    due_now = (p == 0) ? (rq0.size() > 0 && rq0[0].cyc <= cyc)
                                       : (rq1.size() > 0 && rq1[0].cyc <= cyc);
                    if (due_now) begin
                        re = (p == 0) ? rq0.pop_front() : rq1.pop_front();
                        chk("rvalid", 64'(rvalid[p]), 64'd1);
                        chk("rdata", 64'(rdata[p]), 64'(re.data));
                        last_rd[p] = re.data;
                    end else if (rvalid[p]) begin
                        chk("rvalid_unexpected", 64'(rvalid[p]), 64'd0);
                    end else begin
                        chk("rdata_hold", 64'(rdata[p]), 64'(last_rd[p]));
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    function automatic bit busy();
        return (q0.size() > 0) || (q1.size() > 0) || t_req[0] || t_req[1] ||
               (rd_pend.size() > 0) || (rq0.size() > 0) || (rq1.size() > 0) || (gq.size() > 0);
    endfunction

    task automatic wait_gnts(input int n, input int lim);
        int i = 0;
        while (gnt_log.size() < n && i < lim) begin @(negedge clk); i++; end
        if (gnt_log.size() < n) chk("gnt_timeout", 64'(gnt_log.size()), 64'(n));
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (busy() && i < lim) begin @(negedge clk); i++; end
        chk("drain", 64'(busy()), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cs", 64'(s_cs), 64'd0);
        chk("rst_read_n", 64'(s_rd_n), 64'd1);
        chk("rst_write_n", 64'(s_wr_n), 64'd1);
        chk("rst_addr", 64'(s_addr), 64'd0);
        chk("rst_wdata", 64'(s_wdata), 64'd0);
        chk("rst_be_n", 64'(s_be), 64'd3);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata0", 64'(rdata[0]), 64'd0);
        chk("rst_rdata1", 64'(rdata[1]), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    initial begin
        int   base;
        cmd_t c;
        int   i;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        // Contention: both ports read continuously; grants alternate from port 0.
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{1'b0, 25'h40 + 25'(k), 16'h0, 2'b00});
            q1.push_back('{1'b0, 25'h1000080 + 25'(k), 16'h0, 2'b00});
        end
        wait_gnts(8, 400);
        for (int k = 0; k < 8; k++) chk("contention_order", 64'(gnt_log[k]), 64'(k % 2));
        drain(400);

        // Single write, no wait states.
        base = gnt_log.size();
        q0.push_back('{1'b1, 25'h100000, 16'h0042, 2'b00});
        wait_gnts(base + 1, 50);
        chk("wr_port", 64'(gnt_log[base]), 64'd0);
        chk("wr_bus_cycles", 64'(last_on_bus), 64'd1);
        drain(50);

        // Waitrequest held for 5 cycles.
        ws_fixed = 5;
        base = gnt_log.size();
        q1.push_back('{1'b1, 25'h0ABCDE, 16'h1234, 2'b01});
        wait_gnts(base + 1, 50);
        chk("hold_port", 64'(gnt_log[base]), 64'd1);
        chk("hold_bus_cycles", 64'(last_on_bus), 64'd6);
        ws_fixed = 0;
        drain(50);

        // Read routing: m0@0x10, m1@0x20, m0@0x30 with fixed return data.
        ret_data.push_back(16'hAAAA); ret_data.push_back(16'hBBBB); ret_data.push_back(16'hCCCC);
        base = rd_log_port.size();
        q0.push_back('{1'b0, 25'h10, 16'h0, 2'b00});
        wait_gnts(gnt_log.size() + 1, 50);
        q1.push_back('{1'b0, 25'h20, 16'h0, 2'b00});
        wait_gnts(gnt_log.size() + 1, 50);
        q0.push_back('{1'b0, 25'h30, 16'h0, 2'b00});
        wait_gnts(gnt_log.size() + 1, 50);
        drain(100);
        chk("route_port0", 64'(rd_log_port[base]), 64'd0);
        chk("route_data0", 64'(rd_log_data[base]), 64'hAAAA);
        chk("route_port1", 64'(rd_log_port[base + 1]), 64'd1);
        chk("route_data1", 64'(rd_log_data[base + 1]), 64'hBBBB);
        chk("route_port2", 64'(rd_log_port[base + 2]), 64'd0);
        chk("route_data2", 64'(rd_log_data[base + 2]), 64'hCCCC);

        // FIFO full: four outstanding reads block a fifth, m1 write still proceeds.
        ret_hold = 1;
        base = gnt_log.size();
        for (int k = 0; k < 5; k++) q0.push_back('{1'b0, 25'h200 + 25'(k), 16'h0, 2'b00});
        wait_gnts(base + 4, 100);
        q1.push_back('{1'b1, 25'h1000300, 16'h7777, 2'b00});
        wait_gnts(base + 5, 50);
        chk("full_write_port", 64'(gnt_log[base + 4]), 64'd1);
        repeat (10) @(negedge clk);
        chk("full_stall", 64'(gnt_log.size()), 64'(base + 5));
        ret_hold = 0;
        wait_gnts(base + 6, 50);
        chk("full_resume_port", 64'(gnt_log[base + 5]), 64'd0);
        drain(200);

        // Randomised traffic: random wait states, return delays and payloads.
        ws_fixed = -1;
        ret_dly  = -1;
        base = gnt_log.size();
        for (int k = 0; k < 30; k++) begin
            for (int p = 0; p < 2; p++) begin
                c.we    = 1'($urandom);
                c.addr  = {1'(p), 24'($urandom)};
                c.wdata = 16'($urandom);
                c.be_n  = 2'($urandom);
                if (p == 0) q0.push_back(c); else q1.push_back(c);
            end
        end
        wait_gnts(base + 60, 5000);
        drain(500);
        ws_fixed = 0;
        ret_dly  = 4;

        // Warm reset while a command is held in ISSUE.
        ws_fixed = 1000;
        base = gnt_log.size();
        q0.push_back('{1'b1, 25'h0155555, 16'h5A5A, 2'b10});
        i = 0;
        while (!s_cs && i < 20) begin @(negedge clk); i++; end
        chk("issue_seen", 64'(s_cs), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        ws_fixed = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        wait_gnts(base + 1, 50);
        chk("post_reset_port", 64'(gnt_log[base]), 64'd0);
        drain(50);

        // readdatavalid with nothing pending: err sets and stays set.
        chk("err_before", 64'(err), 64'd0);
        #3 inj_req = inj_req + 1;
        repeat (2) @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
